// File: rtl/sim_spi_ram_sync.sv
// Clock-synchronous mode-0 SPI RAM model: READ, FAST_READ, WRITE.
// Oversamples spi_clk on clk; debug read port and write monitor strobe.
module sim_spi_ram_sync #(
    parameter int    ADDR_BITS  = 24,
    parameter int    MEM_BYTES  = 65536,
    parameter int    DUMMY_CLKS = 8,
    parameter string INIT_FILE  = ""
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 spi_clk,
    input  logic                 spi_mosi,
    input  logic                 spi_select,
    output logic                 spi_miso,
    input  logic [ADDR_BITS-1:0] debug_addr,
    output logic [31:0]          debug_data,
    output logic                 wr_valid,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [7:0]           wr_data
);

    localparam int IDX_BITS = $clog2(MEM_BYTES);
    localparam int CNT_A    = (ADDR_BITS > 8) ? ADDR_BITS : 8;
    localparam int CNT_MAX  = (DUMMY_CLKS > CNT_A) ? DUMMY_CLKS : CNT_A;
    localparam int CNT_W    = $clog2(CNT_MAX);
    localparam int DUMMY_M1 = (DUMMY_CLKS > 0) ? DUMMY_CLKS - 1 : 0;

    localparam logic [CNT_W-1:0] BYTE_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_BITS - 1);
    localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_M1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_FAST  = 8'h0B;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    typedef enum logic [2:0] {
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_READ,
        S_WRITE,
        S_IGNORE
    } state_t;

    state_t               state;
    logic                 spi_clk_q;
    logic [CNT_W-1:0]     bit_cnt;
    logic [7:0]           cmd;
    logic [ADDR_BITS-1:0] addr;
    logic [7:0]           shreg;

    logic [7:0] mem [MEM_BYTES];

    logic                 rise;
    logic                 fall;
    logic [7:0]           cmd_nxt;
    logic [7:0]           byte_nxt;
    logic [ADDR_BITS-1:0] addr_nxt;
    logic [ADDR_BITS-1:0] addr_inc;
    logic [IDX_BITS-1:0]  cur_idx;
    logic [IDX_BITS-1:0]  nxt_idx;
    logic [IDX_BITS-1:0]  inc_idx;
    logic [7:0]           rd_cur;
    logic [7:0]           rd_nxt;
    logic [7:0]           rd_inc;
    logic                 mem_we;
    logic                 cmd_known;

    assign rise     = spi_clk & ~spi_clk_q;
    assign fall     = ~spi_clk & spi_clk_q;
    assign cmd_nxt  = {cmd[6:0], spi_mosi};
    assign byte_nxt = {shreg[6:0], spi_mosi};
    assign addr_nxt = {addr[ADDR_BITS-2:0], spi_mosi};
    assign addr_inc = addr + ADDR_BITS'(1);

    // Memory index drops the address bits above the array size
    assign cur_idx = addr[IDX_BITS-1:0];
    assign nxt_idx = addr_nxt[IDX_BITS-1:0];
    assign inc_idx = addr_inc[IDX_BITS-1:0];
    assign rd_cur  = mem[cur_idx];
    assign rd_nxt  = mem[nxt_idx];
    assign rd_inc  = mem[inc_idx];

    assign cmd_known = (cmd_nxt == CMD_READ) ||
                       (cmd_nxt == CMD_FAST) ||
                       (cmd_nxt == CMD_WRITE);

    assign mem_we = rstn && !spi_select && rise &&
                    (state == S_WRITE) && (bit_cnt == BYTE_LAST);

    always_ff @(posedge clk) begin
        if (mem_we) mem[cur_idx] <= byte_nxt;
    end

    logic [IDX_BITS-1:0] dbg_i0;
    logic [IDX_BITS-1:0] dbg_i1;
    logic [IDX_BITS-1:0] dbg_i2;
    logic [IDX_BITS-1:0] dbg_i3;
    logic                unused_dbg;

    assign dbg_i0     = debug_addr[IDX_BITS-1:0];
    assign dbg_i1     = dbg_i0 + IDX_BITS'(1);
    assign dbg_i2     = dbg_i0 + IDX_BITS'(2);
    assign dbg_i3     = dbg_i0 + IDX_BITS'(3);
    assign unused_dbg = ^debug_addr;

    // Reads the pre-write value when an SPI write hits the same byte
    always_ff @(posedge clk) begin
        if (!rstn) begin
            debug_data <= '0;
        end else begin
            debug_data <= {mem[dbg_i3], mem[dbg_i2],
                           mem[dbg_i1], mem[dbg_i0]};
        end
    end

    always_ff @(posedge clk) begin
        wr_valid <= 1'b0;
        if (!rstn) begin
            state     <= S_CMD;
            spi_clk_q <= 1'b0;
            bit_cnt   <= '0;
            cmd       <= '0;
            addr      <= '0;
            shreg     <= '0;
            spi_miso  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            spi_clk_q <= spi_clk;
            if (spi_select) begin
                state    <= S_CMD;
                bit_cnt  <= '0;
                spi_miso <= 1'b0;
            end else begin
                unique case (state)
                    S_CMD: begin
                        if (rise) begin
                            cmd <= cmd_nxt;
                            if (bit_cnt == BYTE_LAST) begin
                                bit_cnt <= '0;
                                state   <= cmd_known ? S_ADDR : S_IGNORE;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_ONE;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (rise) begin
                            addr <= addr_nxt;
                            if (bit_cnt == ADDR_LAST) begin
                                bit_cnt <= '0;
                                if (cmd == CMD_WRITE) begin
                                    state <= S_WRITE;
                                end else if (cmd == CMD_FAST && DUMMY_CLKS > 0) begin
                                    state <= S_DUMMY;
                                end else begin
                                    state <= S_READ;
                                    shreg <= rd_nxt;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CNT_ONE;
                            end
                        end
                    end
                    S_DUMMY: begin
                        if (rise) begin
                            if (bit_cnt == DUMMY_LAST) begin
                                bit_cnt <= '0;
                                state   <= S_READ;
                                shreg   <= rd_cur;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_ONE;
                            end
                        end
                    end
                    S_READ: begin
                        if (fall) begin
                            spi_miso <= shreg[7];
                            if (bit_cnt == BYTE_LAST) begin
                                bit_cnt <= '0;
                                addr    <= addr_inc;
                                shreg   <= rd_inc;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_ONE;
                                shreg   <= {shreg[6:0], 1'b0};
                            end
                        end
                    end
                    S_WRITE: begin
                        if (rise) begin
                            shreg <= byte_nxt;
                            if (bit_cnt == BYTE_LAST) begin
                                bit_cnt  <= '0;
                                wr_valid <= 1'b1;
                                wr_addr  <= addr;
                                wr_data  <= byte_nxt;
                                addr     <= addr_inc;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_ONE;
                            end
                        end
                    end
                    S_IGNORE: begin
                        spi_miso <= 1'b0;
                    end
                    default: begin
                        state <= S_CMD;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sim_spi_ram_sync.sv
// Bench for sim_spi_ram_sync: vector table plus byte scoreboards.
// A second instance with no dummy clocks shares the SPI bus.
module tb_sim_spi_ram_sync;

    logic        clk = 1'b0;
    logic        rstn;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_select;
    logic [23:0] debug_addr;

    logic        spi_miso;
    logic [31:0] debug_data;
    logic        wr_valid;
    logic [23:0] wr_addr;
    logic [7:0]  wr_data;

    logic        nd_miso;
    logic [31:0] nd_debug_data;
    logic        nd_wr_valid;
    logic [23:0] nd_wr_addr;
    logic [7:0]  nd_wr_data;

    always #5 clk = ~clk;

    sim_spi_ram_sync #(
        .ADDR_BITS(24), .MEM_BYTES(65536), .DUMMY_CLKS(8), .INIT_FILE("")
    ) dut (
        .clk(clk), .rstn(rstn),
        .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_select(spi_select),
        .spi_miso(spi_miso),
        .debug_addr(debug_addr), .debug_data(debug_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    sim_spi_ram_sync #(
        .ADDR_BITS(24), .MEM_BYTES(65536), .DUMMY_CLKS(0), .INIT_FILE("")
    ) dut_nd (
        .clk(clk), .rstn(rstn),
        .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_select(spi_select),
        .spi_miso(nd_miso),
        .debug_addr(debug_addr), .debug_data(nd_debug_data),
        .wr_valid(nd_wr_valid), .wr_addr(nd_wr_addr), .wr_data(nd_wr_data)
    );

    wire unused_nd = ^{nd_debug_data, nd_wr_valid, nd_wr_addr, nd_wr_data};

    int errors = 0;
    int checks = 0;
    int wr_seen = 0;

    logic [7:0]  exp_q [$];
    logic [31:0] wr_q [$];

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          n;
        logic [31:0] wdata;
        bit          dbg;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 10;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input string name, input logic [7:0] got);
        logic [7:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got %h with empty scoreboard", name, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", name, got, e);
            end
        end
    endtask

    // Write monitor: every strobe must match the next expected byte
    always @(negedge clk) begin
        logic [31:0] e;
        if (rstn === 1'b1 && wr_valid === 1'b1) begin
            wr_seen++;
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got addr %h data %h expected none",
                         wr_addr, wr_data);
            end else begin
                e = wr_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    errors++;
                    $display("FAIL wr_byte: got %h expected %h",
                             {wr_addr, wr_data}, e);
                end
            end
        end
    end

    task automatic spi_bit(input logic m, output logic s, output logic s0);
        spi_mosi = m;
        spi_clk  = 1'b0;
        repeat (2) @(negedge clk);
        s  = spi_miso;
        s0 = nd_miso;
        spi_clk = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] mo, output logic [7:0] mi,
                        output logic [7:0] mi0);
        logic s, s0;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(mo[i], s, s0);
            mi[i]  = s;
            mi0[i] = s0;
        end
    endtask

    task automatic sel();
        spi_clk    = 1'b0;
        spi_select = 1'b0;
        @(negedge clk);
    endtask

    task automatic desel();
        spi_clk    = 1'b0;
        spi_mosi   = 1'b0;
        spi_select = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic start(input logic [7:0] c, input logic [23:0] a);
        logic [7:0] b, b0;
        sel();
        xfer(c, b, b0);
        xfer(a[23:16], b, b0);
        xfer(a[15:8], b, b0);
        xfer(a[7:0], b, b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        t;
        logic [7:0]  b, b0;
        logic [2:0]  part;
        logic        s, s0;
        int          wr_before;

        tbl[0] = '{8'h02, 24'h000100, 4, 32'hEFBEADDE, 1'b1, 32'hEFBEADDE};
        tbl[1] = '{8'h02, 24'h00FFFE, 4, 32'h44332211, 1'b1, 32'h44332211};
        tbl[2] = '{8'h02, 24'h000010, 2, 32'h00003CA5, 1'b0, 32'h0};
        tbl[3] = '{8'h02, 24'h000020, 1, 32'h0000005A, 1'b0, 32'h0};
        tbl[4] = '{8'h03, 24'h00FFFE, 4, 32'h0, 1'b0, 32'h44332211};
        tbl[5] = '{8'h03, 24'h000100, 4, 32'h0, 1'b0, 32'hEFBEADDE};
        tbl[6] = '{8'h0B, 24'h000010, 2, 32'h0, 1'b0, 32'h00003CA5};
        tbl[7] = '{8'h03, 24'h010100, 2, 32'h0, 1'b0, 32'h0000ADDE};
        tbl[8] = '{8'h02, 24'hFFFFFF, 2, 32'h00008877, 1'b0, 32'h0};
        tbl[9] = '{8'h03, 24'h00FFFE, 4, 32'h0, 1'b0, 32'h44887711};

        rstn       = 1'b0;
        spi_clk    = 1'b0;
        spi_mosi   = 1'b0;
        spi_select = 1'b1;
        debug_addr = 24'h0;
        repeat (3) @(negedge clk);
        check("reset_miso", {31'b0, spi_miso}, 32'h0);
        check("reset_wr_valid", {31'b0, wr_valid}, 32'h0);
        check("reset_wr_addr", {8'h0, wr_addr}, 32'h0);
        check("reset_wr_data", {24'h0, wr_data}, 32'h0);
        check("reset_debug", debug_data, 32'h0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < NV; v++) begin
            t = tbl[v];
            start(t.cmd, t.addr);
            if (t.cmd == 8'h02) begin
                for (int k = 0; k < t.n; k++) begin
                    wr_q.push_back({t.addr + 24'(k), t.wdata[8*k +: 8]});
                    xfer(t.wdata[8*k +: 8], b, b0);
                end
            end else begin
                if (t.cmd == 8'h0B) begin
                    for (int d = 0; d < 8; d++) spi_bit(1'b0, s, s0);
                end
                for (int k = 0; k < t.n; k++) exp_q.push_back(t.exp[8*k +: 8]);
                for (int k = 0; k < t.n; k++) begin
                    xfer(8'h00, b, b0);
                    sb_pop($sformatf("vec%0d_byte%0d", v, k), b);
                end
            end
            desel();
            if (t.dbg) begin
                debug_addr = t.addr;
                repeat (2) @(negedge clk);
                check($sformatf("vec%0d_debug", v), debug_data, t.exp);
            end
        end
        check("wr_q_drained", wr_q.size(), 0);

        // Partial write byte must be discarded on deselect
        wr_before = wr_seen;
        start(8'h02, 24'h000020);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, s, s0);
        desel();
        repeat (2) @(negedge clk);
        check("abort_no_wr", wr_seen, wr_before);
        debug_addr = 24'h000020;
        repeat (2) @(negedge clk);
        check("abort_debug", debug_data & 32'hFF, 32'h5A);
        start(8'h03, 24'h000020);
        exp_q.push_back(8'h5A);
        xfer(8'h00, b, b0);
        sb_pop("abort_readback", b);
        desel();

        // Unknown command: miso low throughout, nothing written
        wr_before = wr_seen;
        sel();
        xfer(8'h9F, b, b0);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(8'h00);
            xfer(8'h02 + 8'(k), b, b0);
            sb_pop($sformatf("ignore_miso%0d", k), b);
        end
        desel();
        check("ignore_no_wr", wr_seen, wr_before);
        debug_addr = 24'h000100;
        repeat (2) @(negedge clk);
        check("ignore_debug", debug_data, 32'hEFBEADDE);

        // FAST_READ with zero dummy clocks on the second instance
        start(8'h0B, 24'h000100);
        exp_q.push_back(8'hDE);
        exp_q.push_back(8'hAD);
        xfer(8'h00, b, b0);
        sb_pop("nodummy_byte0", b0);
        xfer(8'h00, b, b0);
        sb_pop("nodummy_byte1", b0);
        desel();

        // Reset in the middle of a read
        debug_addr = 24'h000020;
        start(8'h03, 24'h000100);
        exp_q.push_back(8'hDE);
        xfer(8'h00, b, b0);
        sb_pop("rst_pre_byte", b);
        for (int i = 2; i >= 0; i--) begin
            spi_bit(1'b0, s, s0);
            part[i] = s;
        end
        check("rst_pre_bits", {29'b0, part}, 32'h5);
        rstn = 1'b0;
        @(negedge clk);
        check("rst_mid_miso", {31'b0, spi_miso}, 32'h0);
        check("rst_mid_wr_data", {24'h0, wr_data}, 32'h0);
        check("rst_mid_debug", debug_data, 32'h0);
        rstn = 1'b1;
        @(negedge clk);
        desel();
        start(8'h03, 24'h000100);
        for (int k = 0; k < 4; k++) exp_q.push_back(tbl[0].wdata[8*k +: 8]);
        for (int k = 0; k < 4; k++) begin
            xfer(8'h00, b, b0);
            sb_pop($sformatf("rst_after_byte%0d", k), b);
        end
        desel();

        check("exp_q_drained", exp_q.size(), 0);
        check("wr_q_final", wr_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
